stream_mux_n_1: RTL

Clocked N:1 stream multiplexer with round-robin arbitration and valid/ready handshakes on every port. It merges CHANNELS independent input streams onto one registered output stream and tags each output word with its source channel number. It is the collecting end of the channel-splitting path: the downstream stream demultiplexer uses Select_Out to route each word back to its channel.

---
 rtl/stream_mux_n_1_if.sv | 29 ++
 rtl/stream_mux_n_1.sv | 95 +++++++++
 2 files changed

// File: rtl/stream_mux_n_1_if.sv
// Purpose: stream bundle for the N:1 mux: CHANNELS input streams in, one tagged stream out.
// Latency: none (wires only).
// Backpressure: Ready_Out per input channel, Ready_In from downstream.
// Ports: Data_In/Valid_In/Ready_Out face the sources;
//        Data_Out/Select_Out/Valid_Out/Ready_In face the sink.
// Modports: master is the mux side, slave is the environment driving the sources and sink.
interface stream_mux_n_1_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS*DATA_WIDTH-1:0] Data_In;
    logic [CHANNELS-1:0]            Valid_In;
    logic [CHANNELS-1:0]            Ready_Out;
    logic [DATA_WIDTH-1:0]          Data_Out;
    logic [SEL_WIDTH-1:0]           Select_Out;
    logic                           Valid_Out;
    logic                           Ready_In;

    modport master (
        input  Data_In, Valid_In, Ready_In,
        output Ready_Out, Data_Out, Select_Out, Valid_Out
    );

    modport slave (
        output Data_In, Valid_In, Ready_In,
        input  Ready_Out, Data_Out, Select_Out, Valid_Out
    );
endinterface

// File: rtl/stream_mux_n_1.sv
// Purpose: round-robin N:1 stream mux; output word tagged with its source channel.
// Latency: 1 cycle from input transfer to Valid_Out/Data_Out.
// Backpressure: Ready_Out granted only when the output register is empty or draining this cycle.
// Ports: Clock_In (rising edge), Reset_N_In (async active-low), Enable_In (gates new grants),
//        bus (master modport of stream_mux_n_1_if) carrying all stream handshakes.
module stream_mux_n_1 #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic               Clock_In,
    input  logic               Reset_N_In,
    input  logic               Enable_In,
    stream_mux_n_1_if.master   bus
);
    localparam int SEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

    logic                    cand_vld;
    logic [SEL_WIDTH-1:0]    cand_idx;
    logic                    slot_free;
    logic                    grant;
    logic [CHANNELS-1:0]     ready_out;

    // Channel index base+off modulo CHANNELS; off never exceeds CHANNELS-1,
    // so a single conditional subtract covers non-power-of-two counts.
    function automatic logic [SEL_WIDTH-1:0] ring_idx(input logic [SEL_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= CHANNELS) begin
            s = s - CHANNELS;
        end
        return s[SEL_WIDTH-1:0];
    endfunction

    always_comb begin
        cand_vld  = 1'b0;
        cand_idx  = '0;
        ready_out = '0;
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;

        // First valid channel scanning upward from the pointer, wrapping.
        for (int k = 0; k < CHANNELS; k++) begin
            if (!cand_vld && bus.Valid_In[ring_idx(rr_ptr_q, k)]) begin
                cand_vld = 1'b1;
                cand_idx = ring_idx(rr_ptr_q, k);
            end
        end

        slot_free = (state_q == EMPTY) || bus.Ready_In;
        // Reset term keeps Ready_Out low while the register is held in reset.
        grant     = Reset_N_In && Enable_In && cand_vld && slot_free;

        if (grant) begin
            ready_out[cand_idx] = 1'b1;
            state_d             = FULL;
            data_d              = bus.Data_In[cand_idx*DATA_WIDTH +: DATA_WIDTH];
            sel_d               = cand_idx;
            rr_ptr_d            = ring_idx(cand_idx, 1);
        end else if ((state_q == FULL) && bus.Ready_In) begin
            // Word leaves with nothing behind it; data/select keep last values.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.Ready_Out  = ready_out;
    assign bus.Data_Out   = data_q;
    assign bus.Select_Out = sel_q;
    assign bus.Valid_Out  = (state_q == FULL);
endmodule
